dmem_store_buffer: RTL

- Store buffer between the pipeline memory stage and the data RAM port.
- Accepts loads and stores from the memory stage and queues stores in a small FIFO.
- Drains queued stores to the RAM in cycles with no load, and forwards buffered store data to younger loads.
- Holds off the RAM completion signal until every buffered store has reached memory, so the memory dump reflects all committed stores.

---
 rtl/dmem_store_buffer_if.sv | 45 ++++
 rtl/dmem_store_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer_if.sv
// Bus bundle between the memory stage, the store buffer and the data RAM port.
// Slave is the store buffer; master is the pipeline/RAM side that drives it.

`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_OP_NOP
`define MEM_OP_NOP 2'd0
`endif
`ifndef MEM_OP_READ
`define MEM_OP_READ 2'd1
`endif
`ifndef MEM_OP_WRITE
`define MEM_OP_WRITE 2'd2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface dmem_store_buffer_if;
  logic [`MEM_OP_BITS-1:0] req_op;
  logic [`ADDR_WIDTH-1:0]  req_address;
  logic [`DATA_WIDTH-1:0]  req_data;
  logic                    stall;
  logic [`DATA_WIDTH-1:0]  load_data;
  logic [`ADDR_WIDTH-1:0]  ram_address;
  logic [`DATA_WIDTH-1:0]  ram_write_data;
  logic [`MEM_OP_BITS-1:0] ram_mem_op;
  logic [`DATA_WIDTH-1:0]  ram_read_data;
  logic                    complete_in;
  logic                    complete_out;

  modport slave (
    input  req_op, req_address, req_data, ram_read_data, complete_in,
    output stall, load_data, ram_address, ram_write_data, ram_mem_op, complete_out
  );

  modport master (
    output req_op, req_address, req_data, ram_read_data, complete_in,
    input  stall, load_data, ram_address, ram_write_data, ram_mem_op, complete_out
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store buffer between the memory stage and the data RAM port. Stores are
// queued in a small FIFO and drained in cycles without a load; loads are
// served at zero latency with forwarding from the youngest buffered store.
// Completion is held back until every buffered store has reached the RAM.

`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_OP_NOP
`define MEM_OP_NOP 2'd0
`endif
`ifndef MEM_OP_READ
`define MEM_OP_READ 2'd1
`endif
`ifndef MEM_OP_WRITE
`define MEM_OP_WRITE 2'd2
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dmem_store_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  dmem_store_buffer_if.slave  bus
);

  logic [`ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [`ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [`DATA_WIDTH-1:0] data_q [DEPTH];
  logic [`DATA_WIDTH-1:0] data_d [DEPTH];

  logic [PTR_BITS-1:0] head_q, head_d;
  logic [PTR_BITS-1:0] tail_q, tail_d;
  logic [PTR_BITS:0]   count_q, count_d;
  logic                complete_pending_q, complete_pending_d;
  logic                complete_out_q, complete_out_d;
  logic                complete_in_q, complete_in_d;

  logic                   is_load, is_store, full, push, drain;
  logic                   fwd_hit;
  logic [`DATA_WIDTH-1:0] fwd_data;

  // Request decode: a load owns the RAM port, so drains only happen otherwise.
  always_comb begin
    is_load  = (bus.req_op == `MEM_OP_READ);
    is_store = (bus.req_op == `MEM_OP_WRITE);
    full     = (count_q == (PTR_BITS+1)'(DEPTH));
    push     = is_store && !full;
    drain    = !is_load && (count_q != '0);
  end

  // Forwarding: walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PTR_BITS-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_BITS'(i);
      if (((PTR_BITS+1)'(i) < count_q) && (addr_q[idx] == bus.req_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // RAM port and pipeline-facing outputs.
  always_comb begin
    bus.ram_mem_op     = `MEM_OP_NOP;
    bus.ram_address    = '0;
    bus.ram_write_data = '0;
    if (is_load) begin
      bus.ram_mem_op  = `MEM_OP_READ;
      bus.ram_address = bus.req_address;
    end else if (drain) begin
      bus.ram_mem_op     = `MEM_OP_WRITE;
      bus.ram_address    = addr_q[head_q];
      bus.ram_write_data = data_q[head_q];
    end
    bus.load_data    = fwd_hit ? fwd_data : bus.ram_read_data;
    bus.stall        = is_store && full;
    bus.complete_out = complete_out_q;
  end

  // Next-state for FIFO storage, pointers, occupancy and completion tracking.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) begin
      addr_d[tail_q] = bus.req_address;
      data_d[tail_q] = bus.req_data;
      tail_d         = tail_q + 1'b1;
    end
    if (drain) begin
      head_d = head_q + 1'b1;
    end
    case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    complete_in_d      = bus.complete_in;
    complete_pending_d = complete_pending_q | (bus.complete_in & ~complete_in_q);
    complete_out_d     = complete_out_q | (complete_pending_q && (count_q == '0));
  end

  // Control state: asynchronously cleared, which also discards buffered stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      complete_pending_q <= 1'b0;
      complete_out_q     <= 1'b0;
      complete_in_q      <= 1'b0;
    end else begin
      head_q             <= head_d;
      tail_q             <= tail_d;
      count_q            <= count_d;
      complete_pending_q <= complete_pending_d;
      complete_out_q     <= complete_out_d;
      complete_in_q      <= complete_in_d;
    end
  end

  // Entry storage: contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule
